// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES encrypt/decrypt round engine, one round per clock
// on a 128-bit state, round keys fetched combinationally from an external key store.
module aes_round_engine #(
  parameter int NR = 10,
  parameter bit ENABLE_DEC = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode_in,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy,
  input  logic         flush
);
  if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
    $fatal(1, "aes_round_engine: NR must be 10, 12 or 14");
  end
  localparam logic [3:0] NRW = 4'(NR);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;
  state_t st, st_n;
  logic [3:0] cnt;
  logic mode, dec_in, accept, last;
  logic [127:0] blk, sr_sb, pre, ark, nxt;
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = xt(x);
    end
    return r;
  endfunction
  // Field inverse as a^254 (0 maps to 0), built from a^127 by square-and-multiply
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gm(gm(r, r), a);
    return gm(r, r);
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction
  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] g;
    g = ginv(a);
    return g ^ rl(g, 1) ^ rl(g, 2) ^ rl(g, 3) ^ rl(g, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    for (int i = 0; i < 16; i++) s[8*i +: 8] = inv ? isb(s[8*i +: 8]) : sb(s[8*i +: 8]);
    return s;
  endfunction
  // Byte 4*c+r sits at bits 127-8*(4*c+r); row r rotates left by r (right when inverse)
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((inv ? c - r + 4 : c + r) % 4)+r) -: 8];
    return o;
  endfunction
  function automatic logic [7:0] cf(input logic inv, input int k);
    return inv ? (k == 0 ? 8'h0e : k == 1 ? 8'h0b : k == 2 ? 8'h0d : 8'h09)
               : (k == 0 ? 8'h02 : k == 1 ? 8'h03 : 8'h01);
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0] v;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        v = '0;
        for (int j = 0; j < 4; j++) v ^= gm(s[127-32*c-8*j -: 8], cf(inv, (j - r + 4) % 4));
        o[127-32*c-8*r -: 8] = v;
      end
    return o;
  endfunction
  assign dec_in = ENABLE_DEC && mode_in;
  assign busy = st == ROUND;
  assign last = cnt == NRW;
  assign in_ready = !flush && (st == IDLE || (st == DONE && out_ready));
  assign accept = in_valid && in_ready;
  assign rk_idx = busy ? (mode ? NRW - cnt : cnt) : (dec_in ? NRW : 4'd0);
  assign sr_sb = mode ? sub_bytes(shift_rows(blk, 1'b1), 1'b1) : shift_rows(sub_bytes(blk, 1'b0), 1'b0);
  assign pre = (mode || last) ? sr_sb : mix_columns(sr_sb, 1'b0);
  assign ark = pre ^ rk_in;
  assign nxt = (mode && !last) ? mix_columns(ark, 1'b1) : ark;
  always_comb begin
    st_n = st;
    st_n = flush ? IDLE : accept ? ROUND : (busy && last) ? DONE :
           (st == DONE && out_ready) ? IDLE : st;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      mode <= 1'b0;
      blk <= '0;
      data_out <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      blk <= data_in ^ rk_in;
      mode <= dec_in;
      cnt <= 4'd1;
      out_valid <= 1'b0;
    end else if (busy) begin
      blk <= nxt;
      if (last) begin
        data_out <= nxt;
        out_valid <= 1'b1;
      end else cnt <= cnt + 4'd1;
    end else if (st == DONE && out_ready) out_valid <= 1'b0;
endmodule
